// File: rtl/reg_access_ctrl_pkg.sv
// Shared definitions for the register access controller: FSM state encoding
// and the default data, address and register-count parameters.
package reg_access_ctrl_pkg;

  localparam int unsigned DEF_DATA_W   = 16;
  localparam int unsigned DEF_NUM_REGS = 4;
  localparam int unsigned DEF_ADDR_W   = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/rdata_or_reduce.sv
// OR-reduction of NUM_REGS register read buses into one word.
module rdata_or_reduce #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_REGS = 4
) (
  input  logic [NUM_REGS*DATA_W-1:0] rdata,
  output logic [DATA_W-1:0]          rdata_or
);

  // Unselected registers drive zero, so a plain OR yields the selected word.
  always_comb begin
    rdata_or = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      rdata_or = rdata_or | rdata[i*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/reg_access_ctrl.sv
// Request/response front end for a bank of simple registers: one request is
// latched, presented to the registers for a single cycle, then answered.
module reg_access_ctrl
  import reg_access_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned ADDR_W   = DEF_ADDR_W
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_wr,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [DATA_W-1:0]          req_wdata,
  output logic [NUM_REGS-1:0]        sel,
  output logic                       wr,
  output logic [DATA_W-1:0]          wdata,
  input  logic [NUM_REGS*DATA_W-1:0] rdata,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W-1:0]          rsp_data,
  output logic                       rsp_err
);

  state_e              state_q, state_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]   rd_or;
  logic                in_range;

  rdata_or_reduce #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS)
  ) u_rdata_or_reduce (
    .rdata   (rdata),
    .rdata_or(rd_or)
  );

  assign in_range  = (32'(addr_q) < NUM_REGS);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    req_ready  = 1'b0;
    sel        = '0;
    wr         = 1'b0;
    wdata      = '0;
    rsp_valid  = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          wr_d    = req_wr;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // Decoding only indices below NUM_REGS leaves sel all-zero when out of range.
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
          sel[i] = (addr_q == ADDR_W'(i));
        end
        wr         = wr_q;
        wdata      = wdata_q;
        rsp_err_d  = ~in_range;
        rsp_data_d = (!wr_q && in_range) ? rd_or : '0;
        state_d    = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Bench for reg_access_ctrl: a 4-register instance checked every cycle against a
// transaction-level model, plus a 3-register instance for out-of-range access.
module tb_reg_access_ctrl;

  logic        clk;
  logic        rstn;

  logic        req_valid, req_ready, req_wr;
  logic [1:0]  req_addr;
  logic [15:0] req_wdata;
  logic [3:0]  sel;
  logic        wr;
  logic [15:0] wdata;
  logic [63:0] rdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [15:0] rsp_data;

  logic        b_req_valid, b_req_ready, b_req_wr;
  logic [1:0]  b_req_addr;
  logic [15:0] b_req_wdata;
  logic [2:0]  b_sel;
  logic        b_wr;
  logic [15:0] b_wdata;
  logic [47:0] b_rdata;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [15:0] b_rsp_data;

  int total = 0;
  int bad   = 0;

  reg_access_ctrl #(.DATA_W(16), .NUM_REGS(4), .ADDR_W(2)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .sel(sel), .wr(wr), .wdata(wdata), .rdata(rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  reg_access_ctrl #(.DATA_W(16), .NUM_REGS(3), .ADDR_W(2)) dut_b (
    .clk(clk), .rstn(rstn),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wr(b_req_wr),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .sel(b_sel), .wr(b_wr), .wdata(b_wdata), .rdata(b_rdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_data(b_rsp_data), .rsp_err(b_rsp_err)
  );

  always #5 clk = ~clk;

  // Attached registers: written on sel&wr, drive their value only when read-selected.
  logic [15:0] regs   [4];
  logic [15:0] regs_b [3];

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) if (sel[i] && wr) regs[i] <= wdata;
    for (int i = 0; i < 3; i++) if (b_sel[i] && b_wr) regs_b[i] <= b_wdata;
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < 4; i++) rdata[i*16 +: 16] = (sel[i] && !wr) ? regs[i] : 16'h0;
  end

  always_comb begin
    b_rdata = '0;
    for (int i = 0; i < 3; i++) b_rdata[i*16 +: 16] = (b_sel[i] && !b_wr) ? regs_b[i] : 16'h0;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: m_age is cycles since the request was taken (-1 = none pending).
  int          m_age;
  logic        m_wr;
  logic [1:0]  m_addr;
  logic [15:0] m_wd;
  logic [15:0] m_mem [4];
  logic [15:0] m_rsp;
  logic        m_err;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_age = -1;
      m_rsp = 16'h0;
      m_err = 1'b0;
    end else if (m_age < 0) begin
      if (req_valid) begin
        m_wr   = req_wr;
        m_addr = req_addr;
        m_wd   = req_wdata;
        m_age  = 0;
      end
    end else if (m_age == 0) begin
      if (m_wr) m_mem[m_addr] = m_wd;
      m_rsp = m_wr ? 16'h0 : m_mem[m_addr];
      m_err = 1'b0;
      m_age = 1;
    end else if (rsp_ready) begin
      m_age = -1;
    end else begin
      m_age = m_age + 1;
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      chk("m_req_ready", 64'(req_ready), 64'(m_age < 0));
      chk("m_sel",       64'(sel),       (m_age == 0) ? (64'd1 << m_addr) : 64'd0);
      chk("m_wr",        64'(wr),        (m_age == 0) ? 64'(m_wr) : 64'd0);
      chk("m_wdata",     64'(wdata),     (m_age == 0) ? 64'(m_wd) : 64'd0);
      chk("m_rsp_valid", 64'(rsp_valid), 64'(m_age >= 1));
      if (m_age >= 1) begin
        chk("m_rsp_data", 64'(rsp_data), 64'(m_rsp));
        chk("m_rsp_err",  64'(rsp_err),  64'(m_err));
      end
    end
  end

  // Called at a falling edge; returns at the falling edge inside the ACCESS cycle.
  task automatic do_req(input logic w, input logic [1:0] a, input logic [15:0] d);
    int n;
    n = 0;
    req_valid = 1'b1; req_wr = w; req_addr = a; req_wdata = d;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) chk("accept_timeout", 64'd0, 64'd1);
    @(negedge clk);
    req_valid = 1'b0; req_wr = ~w; req_addr = ~a; req_wdata = ~d;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) chk("idle_timeout", 64'd0, 64'd1);
  endtask

  int cnt, viol;
  logic prev, s;

  initial begin
    clk = 0; rstn = 0;
    req_valid = 0; req_wr = 0; req_addr = 0; req_wdata = 0; rsp_ready = 1;
    b_req_valid = 0; b_req_wr = 0; b_req_addr = 0; b_req_wdata = 0; b_rsp_ready = 1;
    for (int i = 0; i < 4; i++) begin regs[i] = 16'h0; m_mem[i] = 16'h0; end
    for (int i = 0; i < 3; i++) regs_b[i] = 16'h0;

    repeat (2) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_sel",       64'(sel),       64'd0);
    chk("rst_wdata",     64'(wdata),     64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data",  64'(rsp_data),  64'd0);
    chk("rst_rsp_err",   64'(rsp_err),   64'd0);
    rstn = 1;
    @(negedge clk);

    // Out-of-range write on the 3-register instance
    b_req_valid = 1; b_req_wr = 1; b_req_addr = 2'd3; b_req_wdata = 16'h1234;
    @(negedge clk);
    b_req_valid = 0;
    chk("oor_access_sel", 64'(b_sel), 64'd0);
    chk("oor_access_wr",  64'(b_wr),  64'd1);
    @(negedge clk);
    chk("oor_rsp_valid", 64'(b_rsp_valid), 64'd1);
    chk("oor_rsp_err",   64'(b_rsp_err),   64'd1);
    chk("oor_rsp_data",  64'(b_rsp_data),  64'd0);
    chk("oor_resp_sel",  64'(b_sel),       64'd0);
    @(negedge clk);
    chk("oor_regs", {16'h0, regs_b[0], regs_b[1], regs_b[2]}, 64'd0);
    chk("oor_idle", 64'(b_req_ready), 64'd1);

    // Write A5A5 to register 1
    do_req(1'b1, 2'd1, 16'hA5A5);
    chk("w1_sel",   64'(sel),   64'h2);
    chk("w1_wr",    64'(wr),    64'd1);
    chk("w1_wdata", 64'(wdata), 64'hA5A5);
    @(negedge clk);
    chk("w1_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("w1_rsp_data",  64'(rsp_data),  64'd0);
    chk("w1_rsp_err",   64'(rsp_err),   64'd0);
    @(negedge clk);
    chk("w1_back_idle", 64'(req_ready), 64'd1);

    do_req(1'b1, 2'd0, 16'h1111); wait_idle();
    do_req(1'b1, 2'd3, 16'h3333); wait_idle();
    do_req(1'b1, 2'd2, 16'h00FF); wait_idle();

    // Read back register 1
    do_req(1'b0, 2'd1, 16'h0);
    chk("r1_sel", 64'(sel), 64'h2);
    chk("r1_wr",  64'(wr),  64'd0);
    @(negedge clk);
    chk("r1_rsp_data", 64'(rsp_data), 64'hA5A5);
    wait_idle();
    do_req(1'b0, 2'd3, 16'h0); wait_idle();

    // Backpressure on a read of 00FF while a new request waits
    rsp_ready = 0;
    do_req(1'b0, 2'd2, 16'h0);
    @(negedge clk);
    req_valid = 1; req_wr = 1; req_addr = 2'd0; req_wdata = 16'hBEEF;
    for (int k = 0; k < 5; k++) begin
      chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_rsp_data",  64'(rsp_data),  64'h00FF);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    rsp_ready = 1;
    @(negedge clk);
    chk("bp_release_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 0;
    chk("bp_next_sel",   64'(sel),   64'h1);
    chk("bp_next_wdata", 64'(wdata), 64'hBEEF);
    wait_idle();

    // Reset pulse in the middle of a write access
    do_req(1'b1, 2'd3, 16'hDEAD);
    #2 rstn = 0;
    #1;
    chk("mid_rst_sel",       64'(sel),       64'd0);
    chk("mid_rst_wr",        64'(wr),        64'd0);
    chk("mid_rst_wdata",     64'(wdata),     64'd0);
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_rsp_data",  64'(rsp_data),  64'd0);
    #1 rstn = 1;
    @(negedge clk);
    chk("mid_rst_ready",     64'(req_ready), 64'd1);
    chk("mid_rst_no_rsp",    64'(rsp_valid), 64'd0);
    chk("mid_rst_reg3",      64'(regs[3]),   64'h3333);
    do_req(1'b0, 2'd3, 16'h0); wait_idle();

    // Back-to-back reads with valid and ready held high
    req_valid = 1; req_wr = 0; req_addr = 2'd1; req_wdata = 16'h0;
    cnt = 0; viol = 0; prev = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      s = |sel;
      if (s) cnt++;
      if (s && prev) viol++;
      prev = s;
    end
    req_valid = 0;
    chk("b2b_accesses",    64'(cnt),  64'd4);
    chk("b2b_consecutive", 64'(viol), 64'd0);
    wait_idle();

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_access_ctrl.md
REG_ACCESS_CTRL -- requirements
Module: reg_access_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning the register data width.
REQ-002 SHALL have parameter NUM_REGS, default 4, meaning the count of attached registers.
REQ-003 SHALL have parameter ADDR_W, default 2, meaning the request address width; NUM_REGS <= 2**ADDR_W.
REQ-004 clk  input  1  the single clock; all logic on posedge.
REQ-005 rstn  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  the request is present.
REQ-007 req_ready  output  1  the block accepts a request this cycle.
REQ-008 req_wr  input  1  1=write, 0=read.
REQ-009 req_addr  input  ADDR_W  the target register index.
REQ-010 req_wdata  input  DATA_W  the write data.
REQ-011 sel  output  NUM_REGS  one-hot register select.
REQ-012 wr  output  1  the write strobe to the registers.
REQ-013 wdata  output  DATA_W  the write data to the registers.
REQ-014 rdata  input  NUM_REGS*DATA_W  register read buses; slice i = register i, zero when not read-selected.
REQ-015 rsp_valid  output  1  the response is present.
REQ-016 rsp_ready  input  1  the consumer accepts the response.
REQ-017 rsp_data  output  DATA_W  the read data, or zero for writes and errors.
REQ-018 rsp_err  output  1  req_addr >= NUM_REGS.

Function
REQ-019 SHALL implement FSM states IDLE, ACCESS and RESP.
REQ-020 In IDLE, req_ready=1; req_valid&req_ready latches wr, addr and wdata, then goes to ACCESS.
REQ-021 req_ready SHALL be 0 in ACCESS and RESP; there is no pipelining, and a transaction takes at least 3 cycles.
REQ-022 ACCESS lasts exactly one cycle: sel[addr]=1 (all zero if addr out of range), wr=latched wr, wdata=latched wdata.
REQ-023 In all other states, sel, wr and wdata SHALL be 0.
REQ-024 At the end of ACCESS, a read SHALL register the OR of all rdata slices into rsp_data; a write or error SHALL register 0.
REQ-025 rsp_err SHALL be registered at the end of ACCESS; an out-of-range write asserts no sel, and no register is modified.
REQ-026 RESP: rsp_valid=1; rsp_data and rsp_err are held stable until rsp_ready=1, then the block returns to IDLE the next cycle.
REQ-027 Backpressure: rsp_ready=0 SHALL hold RESP indefinitely, with no timeout.
REQ-028 Request fields outside the acceptance cycle SHALL be ignored; req_valid is not required to stay high after acceptance.

Reset
REQ-029 rstn=0 SHALL immediately force IDLE, sel=0, wr=0, wdata=0, rsp_valid=0, rsp_data=0 and rsp_err=0, independent of clk.
REQ-030 A reset asserted mid-ACCESS or mid-RESP SHALL abort the transaction with no response; req_ready=1 on the first edge after rstn deasserts.

Structure
REQ-031 A shared package SHALL hold the FSM state enum (IDLE/ACCESS/RESP) and the DATA_W/ADDR_W/NUM_REGS defaults.
REQ-032 One sub-module, rdata_or_reduce, SHALL OR NUM_REGS slices of DATA_W into one word; all other logic is in reg_access_ctrl.

Verification
REQ-033 Write addr=1, wdata=16'hA5A5 -> one ACCESS cycle with sel=4'b0010, wr=1, wdata=A5A5; next cycle rsp_valid=1, rsp_data=0, rsp_err=0.
REQ-034 Read addr=1 after REQ-033, with four register_test instances attached -> ACCESS sel=4'b0010, wr=0; RESP rsp_data=16'hA5A5.
REQ-035 Parameters NUM_REGS=3, ADDR_W=2; write addr=3, wdata=16'h1234 -> sel=0 throughout, rsp_err=1, rsp_data=0, no register changed.
REQ-036 rsp_ready=0 for 5 cycles during a read of 16'h00FF -> rsp_valid and rsp_data=00FF held; req_ready=0 while a new req_valid is high; the new request is accepted 1 cycle after rsp_ready=1.
REQ-037 rstn pulsed low during ACCESS of a write -> outputs are zero immediately, no response is produced, and req_ready=1 after release.
REQ-038 Back-to-back requests with req_valid and rsp_ready held high -> one transaction per 3 cycles, with sel never asserted in two consecutive cycles.
